mem_port_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one write port and one read port of the single-port-configured Memory block between NUM_REQ requesters.
- Each requester uses a valid/ready request handshake and gets read data back on a tagged response lane.
- Sits between the core/DMA-style requesters and Memory (READ_PORTS=1, WRITE_PORTS=1), and drives Memory's EnWrite, write_addr, write_data and read_addr directly.

---
 rtl/mem_arb_pkg.sv | 49 ++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 96 +++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for sharing one memory write/read port pair between requesters.
package mem_arb_pkg;

  // Widest supported requester count; owner fields are sized for it so the
  // package does not depend on any one instance's NUM_REQ.
  localparam int MAX_REQ = 8;
  localparam int OWNER_W = $clog2(MAX_REQ);

  typedef logic [OWNER_W-1:0] owner_t;

  // Tag that travels alongside a read while Memory produces its data.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } rsp_tag_t;

  // Round-robin pick: scan valid starting at ptr, wrapping modulo n, and
  // return a one-hot vector with the first set bit found (zero if none).
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input owner_t             ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] grant;
    owner_t             idx;
    logic               found;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = owner_t'((32'(ptr) + k) % n);
      if (k < n && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

  // Index of the set bit of a one-hot vector (zero for an all-zero vector).
  function automatic owner_t onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    owner_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) idx = owner_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a lockable priority pointer. Purely combinational
// pick from the current pointer; pointer advances only on a handshake.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic [NUM_REQ-1:0] lock,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               fire
);

  logic [IW-1:0]      rr_ptr;
  logic               lock_hold;
  logic [NUM_REQ-1:0] scan_grant;
  logic               win_locked;

  // Pick the winner: a locked owner that is still requesting wins outright,
  // otherwise scan from rr_ptr. Nothing is granted while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    scan_grant = NUM_REQ'(rr_pick(MAX_REQ'(valid), OWNER_W'(rr_ptr), NUM_REQ));
    grant      = scan_grant;
    if (lock_hold && valid[rr_ptr]) grant = NUM_REQ'(1) << rr_ptr;
    if (rst) grant = '0;
    grant_idx  = IW'(onehot_to_idx(MAX_REQ'(grant)));
    fire       = |grant;
    win_locked = |(grant & lock);
  end

  // Advance the pointer past the winner, or pin it on the winner when it
  // asked for the lock. Without a handshake the pointer holds.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      rr_ptr    <= '0;
      lock_hold <= 1'b0;
    end else if (fire) begin
      lock_hold <= win_locked;
      if (win_locked)                        rr_ptr <= grant_idx;
      else if (grant_idx == IW'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                   rr_ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares Memory's single write port and single read port between NUM_REQ
// valid/ready requesters and returns read data on a one-hot tagged lane,
// exactly two cycles after the read's handshake cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int IO_SIZE = 32,
  parameter  int ROWS    = 64,
  localparam int AW      = $clog2(ROWS),
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ-1:0][AW-1:0]      req_addr,
  input  logic [NUM_REQ-1:0][IO_SIZE-1:0] req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [IO_SIZE-1:0]              rsp_data,
  output logic                            mem_we,
  output logic [AW-1:0]                   mem_waddr,
  output logic [IO_SIZE-1:0]              mem_wdata,
  output logic [AW-1:0]                   mem_raddr,
  input  logic [IO_SIZE-1:0]              mem_rdata
);

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      win_idx;
  logic               fire;

  logic               win_we;
  logic [AW-1:0]      win_addr;
  logic [IO_SIZE-1:0] win_wdata;

  rsp_tag_t           s1;
  rsp_tag_t           s2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst       (rst),
    .valid     (req_valid),
    .lock      (req_lock),
    .grant     (grant),
    .grant_idx (win_idx),
    .fire      (fire)
  );

  assign req_ready = grant;

  // Select the winning requester's command fields.
  always_comb begin
    win_we    = req_we[win_idx];
    win_addr  = req_addr[win_idx];
    win_wdata = req_wdata[win_idx];
  end

  // Issue register: drive Memory's ports from the winner and open a read tag.
  // Writes strobe mem_we for one cycle; mem_raddr holds its last value when
  // no read is issued so Memory keeps sampling a stable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_raddr <= '0;
      s1        <= '0;
    end else begin
      mem_we   <= fire && win_we;
      s1.valid <= fire && !win_we;
      s1.owner <= OWNER_W'(win_idx);
      if (fire && win_we) begin
        mem_waddr <= win_addr;
        mem_wdata <= win_wdata;
      end
      if (fire && !win_we) mem_raddr <= win_addr;
    end
  end

  // Second tag stage lines up with the cycle Memory presents read data.
  always_ff @(posedge clk) begin
    if (rst) s2 <= '0;
    else     s2 <= s1;
  end

  // Decode the tag into the one-hot response pulse; data passes straight through.
  always_comb begin
    rsp_valid = s2.valid ? (NUM_REQ'(1) << s2.owner) : '0;
    rsp_data  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: behavioural Memory model plus a
// transaction-level reference (priority pointer, shadow memory, response queue).
module tb_mem_port_arbiter;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int ROWS = 64;
  localparam int AW   = 6;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [N-1:0]             req_valid, req_we, req_lock, req_ready, rsp_valid;
  logic [N-1:0][AW-1:0]     req_addr;
  logic [N-1:0][DW-1:0]     req_wdata;
  logic [DW-1:0]            rsp_data, mem_wdata, mem_rdata;
  logic                     mem_we;
  logic [AW-1:0]            mem_waddr, mem_raddr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .IO_SIZE(DW), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  // Memory block: write commits on negedge, read address sampled on posedge.
  logic [DW-1:0] mem [ROWS];
  always @(negedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  // Requester-side state (held until granted unless keep is set).
  logic [N-1:0]  v, we, lk, keep;
  logic [AW-1:0] ad [N];
  logic [DW-1:0] wd [N];

  // Reference model.
  typedef struct {
    int            due;
    int            owner;
    logic [DW-1:0] data;
  } exp_t;
  exp_t          rq[$];
  logic [DW-1:0] ref_mem [ROWS];
  int            ref_ptr;
  logic          exp_we;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  int            glog[$];
  int            cyc;
  int            checks;
  int            errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_reqs();
    v = '0; we = '0; lk = '0; keep = '0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic l, input logic k);
    v[i] = 1'b1; we[i] = w; ad[i] = a; wd[i] = d; lk[i] = l; keep[i] = k;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cycle(input logic do_rst);
    int   w;
    logic found;
    // Outputs owned by earlier cycles.
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check("rsp_valid", 64'(rsp_valid), 64'(N'(1) << rq[0].owner));
      check("rsp_data", 64'(rsp_data), 64'(rq[0].data));
      void'(rq.pop_front());
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'(0));
    end
    check("mem_we", 64'(mem_we), 64'(exp_we));
    if (exp_we) begin
      check("mem_waddr", 64'(mem_waddr), 64'(exp_waddr));
      check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
    end
    // Drive this cycle's inputs.
    rst       = do_rst;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = ad[i];
      req_wdata[i] = wd[i];
    end
    #1;
    exp_we = 1'b0;
    if (do_rst) begin
      check("ready_in_rst", 64'(req_ready), 64'(0));
      rq.delete();
      ref_ptr = 0;
    end else begin
      found = 1'b0;
      w     = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ref_ptr + k) % N;
        if (!found && v[i]) begin
          found = 1'b1;
          w     = i;
        end
      end
      check("req_ready", 64'(req_ready), found ? 64'(N'(1) << w) : 64'(0));
      if (found) begin
        glog.push_back(w);
        ref_ptr = lk[w] ? w : (w + 1) % N;
        if (we[w]) begin
          ref_mem[ad[w]] = wd[w];
          exp_we    = 1'b1;
          exp_waddr = ad[w];
          exp_wdata = wd[w];
        end else begin
          rq.push_back('{due: cyc + 2, owner: w, data: ref_mem[ad[w]]});
        end
        if (!keep[w]) v[w] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    int lock_exp [8];
    checks = 0; errors = 0; cyc = 0; ref_ptr = 0; exp_we = 1'b0;
    exp_waddr = '0; exp_wdata = '0;
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < N; i++) begin ad[i] = '0; wd[i] = '0; end
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    @(negedge clk);

    // Reset state.
    cycle(1'b1);
    cycle(1'b1);
    check("rst_mem_waddr", 64'(mem_waddr), 64'(0));
    check("rst_mem_raddr", 64'(mem_raddr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));

    // Preload every row through requester 0 (single requester streams).
    for (int a = 0; a < ROWS; a++) begin
      set_req(0, 1'b1, AW'(a), $urandom, 1'b0, 1'b0);
      cycle(1'b0);
    end
    idle(2);

    // Write then read of addr 5 from another requester.
    cycle(1'b1);
    set_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle(1'b0);
    set_req(1, 1'b0, 6'd5, '0, 1'b0, 1'b0);
    cycle(1'b0);
    cycle(1'b0);
    check("t1_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
    check("t1_rsp_data", 64'(rsp_data), 64'(32'hDEADBEEF));
    idle(2);

    // Write addr 63 immediately followed by a read of addr 63.
    set_req(3, 1'b1, 6'd63, 32'h1234_5678, 1'b0, 1'b0);
    cycle(1'b0);
    set_req(2, 1'b0, 6'd63, '0, 1'b0, 1'b0);
    cycle(1'b0);
    cycle(1'b0);
    check("fwd_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check("fwd_rsp_data", 64'(rsp_data), 64'(32'h1234_5678));
    idle(2);

    // All four stream reads of addrs 1..4 from reset: strict rotation.
    cycle(1'b1);
    glog.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 1), '0, 1'b0, 1'b1);
    idle(12);
    for (int i = 0; i < 12; i++) check("rr_order", 64'(glog[i]), 64'(i % N));
    clear_reqs();
    idle(3);

    // Lock: req2 keeps priority until the lock drops, then 3, then 0.
    cycle(1'b1);
    glog.delete();
    set_req(0, 1'b0, 6'd10, '0, 1'b0, 1'b1);
    set_req(1, 1'b0, 6'd11, '0, 1'b0, 1'b1);
    set_req(2, 1'b0, 6'd12, '0, 1'b1, 1'b1);
    idle(5);
    lk[2] = 1'b0;
    set_req(3, 1'b0, 6'd13, '0, 1'b0, 1'b1);
    idle(3);
    lock_exp = '{0, 1, 2, 2, 2, 2, 3, 0};
    for (int i = 0; i < 8; i++) check("lock_order", 64'(glog[i]), 64'(lock_exp[i]));
    clear_reqs();
    idle(3);

    // Reset one cycle after a write handshake: strobe then cancelled.
    set_req(0, 1'b1, 6'd20, 32'hCAFE_0001, 1'b0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    check("rst_cancels_we", 64'(mem_we), 64'(0));
    // Reset one cycle after a read handshake: the response never appears.
    set_req(1, 1'b0, 6'd7, '0, 1'b0, 1'b0);
    cycle(1'b0);
    cycle(1'b1);
    glog.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(30 + i), '0, 1'b0, 1'b0);
    cycle(1'b0);
    check("post_rst_grant", 64'(glog[0]), 64'(0));
    idle(6);

    // Idle cycles interleaved with single requests; pointer must not drift.
    for (int r = 0; r < 4; r++) begin
      set_req(r, 1'b0, AW'(40 + r), '0, 1'b0, 1'b0);
      cycle(1'b0);
      idle(3);
    end
    idle(2);

    // Randomized traffic with occasional lock and reset.
    for (int t = 0; t < 400; t++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom_range(0, 1) == 1, AW'($urandom_range(0, ROWS - 1)),
                  $urandom, $urandom_range(0, 7) == 0, 1'b0);
      end
      cycle(r);
    end
    clear_reqs();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
